grid_io_bank_cfg: RTL and testbench
===================================

Name: grid_io_bank_cfg

Overview:
Parametrised successor to the fixed 8-pad left-side IO grid. It holds NUM_IO bidirectional GPIO pads and adds on-block configuration storage for every pad. A handshaked loader FSM writes that storage, with support for broadcast, range checking, completion tracking and lock. Sits at the fabric edge, between the top-level GPIO pads and the adjacent connection/switch blocks.

Parameters:
NUM_IO, 8, number of pads/IO sub-tiles (1..64)
ADDR_W, 3, width of cfg_addr; must satisfy 2**ADDR_W >= NUM_IO
CFG_BITS, 2, config bits per pad: bit0 = output drive enable, bit1 = input enable (extra bits stored, unused)

Ports:
prog_clk  input  1  programming/fabric clock, rising edge
prog_rst_n  input  1  asynchronous active-low reset
cfg_valid  input  1  config write request
cfg_ready  output  1  loader can accept a write this cycle
cfg_addr  input  ADDR_W  target pad index
cfg_bcast  input  1  write cfg_data to all pads, ignore cfg_addr
cfg_data  input  CFG_BITS  config word
cfg_lock  input  1  request freeze of configuration
cfg_done  output  1  every pad written at least once since reset
cfg_locked  output  1  configuration frozen
cfg_err  output  1  one-cycle pulse on rejected write
gfpga_pad_GPIO_PAD  inout  NUM_IO  top-level pads
io_right_in  output  NUM_IO  pad-to-fabric data
io_right_out  input  NUM_IO  fabric-to-pad data

Behaviour:
- Reset (async assert, sync release): all cfg regs 0, written mask 0, FSM IDLE. Outputs: cfg_ready=1, cfg_done=0, cfg_locked=0, cfg_err=0. All pads tri-stated, io_right_in=0.
- Handshake: write accepted on a cycle with cfg_valid & cfg_ready. cfg_valid held with cfg_ready low is not a transfer.
- FSM states:
  - IDLE: cfg_ready=1. An accepted write goes to WRITE.
  - WRITE: cfg_ready=0. On this edge the data registered at acceptance is stored and the mask updated. Next state is IDLE, or LOCKED if cfg_lock=1 and cfg_done (updated) =1.
  - LOCKED: cfg_ready=1, cfg_locked=1. Every accepted write is rejected (cfg_err pulse, no storage change). Exit only via reset.
- Throughput: max one write per 2 cycles. New cfg value is visible on pad control 2 cycles after the acceptance edge.
- In IDLE, cfg_lock=1 with cfg_done=1 goes to LOCKED next cycle. cfg_lock=1 with cfg_done=0 is ignored.
- Broadcast: writes all NUM_IO pads and sets all mask bits. cfg_addr ignored, never errors.
- Range: non-broadcast cfg_addr >= NUM_IO gives cfg_err=1 the cycle after acceptance, no write, mask unchanged. FSM still passes through WRITE.
- cfg_done = AND of mask; registered, sticky until reset.
- Pad i drives io_right_out[i] when cfg[i][0]=1 AND cfg_done=1; otherwise high-Z.
- io_right_in[i] = gfpga_pad_GPIO_PAD[i] when cfg[i][1]=1, else 0 (combinational, macro off).
- Both enables set: pad drives and io_right_in observes the driven value (loopback).
- Rewriting an already-written pad overwrites the config; the mask is unaffected.
- Reset mid-WRITE: the pending write is discarded and all state is cleared.

Optional Feature:
Macro GRID_IO_INPUT_SYNC_EN.
- Defined: io_right_in passes through a 2-flop synchroniser per pad on prog_clk, reset to 0 by prog_rst_n. Input gating by cfg[i][1] is applied before the first flop. Latency is 2 cycles.
- Undefined: the combinational path described above, no added flops.

Test Plan:
- Reset, then write addr 0..7 with data 2'b11 one by one. cfg_done rises the cycle after the 8th WRITE state, not before. cfg_ready is low exactly one cycle per write.
- After full config with io_right_out=8'hA5: pads read 8'hA5 and io_right_in=8'hA5. Rewrite addr 3 with 2'b00: pad3 goes high-Z and io_right_in[3]=0 two cycles after acceptance.
- NUM_IO=6, write addr 7: cfg_err pulses once, mask unchanged, cfg_done stays 0. A following broadcast of 2'b01 sets cfg_done; pads drive and io_right_in=0.
- Broadcast of 2'b10, external pads driven 6'h2B: io_right_in=6'h2B and no pad driven. Then assert cfg_lock: cfg_locked=1. A write to addr 0 yields cfg_err and the config is unchanged.
- Assert prog_rst_n low asynchronously during WRITE: outputs return to reset values immediately with no clock. After release, cfg_done=0 and all pads are high-Z.
- With GRID_IO_INPUT_SYNC_EN, a pad toggle appears on io_right_in exactly 2 edges later. Without the macro it appears in the same cycle.

Source files
------------

// File: rtl/grid_io_bank_cfg.sv
// grid_io_bank_cfg: NUM_IO bidirectional GPIO pads with per-pad configuration
// storage, written through a valid/ready loader FSM that supports broadcast,
// address range checking, completion tracking and a lock.
// Optional feature macro: GRID_IO_INPUT_SYNC_EN. When it is defined,
// io_right_in passes through a 2-flop synchroniser per pad.
module grid_io_bank_cfg #(
  parameter int NUM_IO   = 8,
  parameter int ADDR_W   = 3,
  parameter int CFG_BITS = 2
) (
  input  logic                prog_clk,
  input  logic                prog_rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic                cfg_bcast,
  input  logic [CFG_BITS-1:0] cfg_data,
  input  logic                cfg_lock,
  output logic                cfg_done,
  output logic                cfg_locked,
  output logic                cfg_err,
  inout  wire  [NUM_IO-1:0]   gfpga_pad_GPIO_PAD,
  output logic [NUM_IO-1:0]   io_right_in,
  input  logic [NUM_IO-1:0]   io_right_out
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t              state_reg;
  logic                ready_reg;
  logic                done_reg;
  logic                locked_reg;
  logic                err_reg;
  logic [NUM_IO-1:0]   mask_reg;
  logic [NUM_IO-1:0]   mask_next;
  logic [NUM_IO-1:0]   write_hit;
  logic [ADDR_W-1:0]   pend_addr_reg;
  logic                pend_bcast_reg;
  logic [CFG_BITS-1:0] pend_data_reg;
  logic [CFG_BITS-1:0] cfg_reg [NUM_IO];
  logic [NUM_IO-1:0]   drive_en;
  logic [NUM_IO-1:0]   in_gated;
  logic                accept;
  logic                addr_in_range;
  logic                done_next;

  assign accept        = cfg_valid & ready_reg;
  assign addr_in_range = (int'(cfg_addr) < NUM_IO);

  // Pads targeted by the pending write. An out-of-range address matches no
  // pad, so a rejected write naturally leaves storage and mask untouched.
  always_comb begin
    write_hit = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      write_hit[i] = pend_bcast_reg || (int'(pend_addr_reg) == i);
    end
  end

  assign mask_next = mask_reg | write_hit;
  assign done_next = done_reg | (&mask_next);

  // Loader FSM: registers the request on acceptance, commits it one edge
  // later in WRITE, and freezes in LOCKED until reset.
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_reg      <= ST_IDLE;
      ready_reg      <= 1'b1;
      done_reg       <= 1'b0;
      locked_reg     <= 1'b0;
      err_reg        <= 1'b0;
      mask_reg       <= '0;
      pend_addr_reg  <= '0;
      pend_bcast_reg <= 1'b0;
      pend_data_reg  <= '0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            pend_addr_reg  <= cfg_addr;
            pend_bcast_reg <= cfg_bcast;
            pend_data_reg  <= cfg_data;
            // Range error is flagged during the WRITE cycle itself.
            err_reg        <= !cfg_bcast && !addr_in_range;
            ready_reg      <= 1'b0;
            state_reg      <= ST_WRITE;
          end else if (cfg_lock && done_reg) begin
            locked_reg <= 1'b1;
            state_reg  <= ST_LOCKED;
          end
        end
        ST_WRITE: begin
          mask_reg  <= mask_next;
          done_reg  <= done_next;
          ready_reg <= 1'b1;
          if (cfg_lock && done_next) begin
            locked_reg <= 1'b1;
            state_reg  <= ST_LOCKED;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_LOCKED: begin
          if (accept) begin
            err_reg <= 1'b1;
          end
        end
        default: begin
          state_reg  <= ST_IDLE;
          ready_reg  <= 1'b1;
          locked_reg <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready  = ready_reg;
  assign cfg_done   = done_reg;
  assign cfg_locked = locked_reg;
  assign cfg_err    = err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IO; gi++) begin : g_pad
      // Per-pad config word, committed only on the WRITE edge.
      always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
          cfg_reg[gi] <= '0;
        end else if (state_reg == ST_WRITE && write_hit[gi]) begin
          cfg_reg[gi] <= pend_data_reg;
        end
      end

      // Outputs stay tri-stated until every pad has been configured.
      assign drive_en[gi]           = cfg_reg[gi][0] & done_reg;
      assign gfpga_pad_GPIO_PAD[gi] = drive_en[gi] ? io_right_out[gi] : 1'bz;
      assign in_gated[gi]           = cfg_reg[gi][1] & gfpga_pad_GPIO_PAD[gi];
    end
  endgenerate

`ifdef GRID_IO_INPUT_SYNC_EN
  logic [NUM_IO-1:0] sync1_reg;
  logic [NUM_IO-1:0] sync2_reg;

  // Two-stage synchroniser on the already-gated pad inputs.
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= in_gated;
      sync2_reg <= sync1_reg;
    end
  end

  assign io_right_in = sync2_reg;
`else
  assign io_right_in = in_gated;
`endif

endmodule

// File: tb/tb_grid_io_bank_cfg.sv
// tb_grid_io_bank_cfg: table-driven directed sequences plus randomized writes,
// all checked against an array-based model of pad configuration state.
module tb_grid_io_bank_cfg;

  localparam int N  = 6;
  localparam int AW = 3;

  logic          prog_clk = 1'b0;
  logic          prog_rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [AW-1:0] cfg_addr = '0;
  logic          cfg_bcast = 1'b0;
  logic [1:0]    cfg_data = '0;
  logic          cfg_lock = 1'b0;
  logic          cfg_done;
  logic          cfg_locked;
  logic          cfg_err;
  wire  [N-1:0]  pad;
  logic [N-1:0]  io_right_in;
  logic [N-1:0]  io_right_out = '0;

  logic [N-1:0]  ext_req = '0;
  logic [N-1:0]  ext_val = '0;
  logic [N-1:0]  ext_en  = '0;

  int n_chk  = 0;
  int n_fail = 0;
  logic last_err_act;

  // Reference model: config words, written flags, lock flag.
  logic [1:0]   m_cfg [N];
  logic [N-1:0] m_wr;
  bit           m_locked;

  grid_io_bank_cfg #(.NUM_IO(N), .ADDR_W(AW), .CFG_BITS(2)) dut (
    .prog_clk           (prog_clk),
    .prog_rst_n         (prog_rst_n),
    .cfg_valid          (cfg_valid),
    .cfg_ready          (cfg_ready),
    .cfg_addr           (cfg_addr),
    .cfg_bcast          (cfg_bcast),
    .cfg_data           (cfg_data),
    .cfg_lock           (cfg_lock),
    .cfg_done           (cfg_done),
    .cfg_locked         (cfg_locked),
    .cfg_err            (cfg_err),
    .gfpga_pad_GPIO_PAD (pad),
    .io_right_in        (io_right_in),
    .io_right_out       (io_right_out)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ext
      pulldown (pad[gi]);
      assign pad[gi] = ext_en[gi] ? ext_val[gi] : 1'bz;
    end
  endgenerate

  always #5 prog_clk = ~prog_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit m_done();
    return &m_wr;
  endfunction

  function automatic logic [N-1:0] m_drive();
    logic [N-1:0] d;
    for (int i = 0; i < N; i++) d[i] = m_cfg[i][0] & m_done();
    return d;
  endfunction

  // Let pad inputs reach io_right_in.
  task automatic settle();
`ifdef GRID_IO_INPUT_SYNC_EN
    repeat (2) @(posedge prog_clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic do_reset();
    @(posedge prog_clk); #1;
    prog_rst_n = 1'b0;
    cfg_valid = 0; cfg_lock = 0; cfg_bcast = 0; ext_req = '0; ext_en = '0;
    for (int i = 0; i < N; i++) m_cfg[i] = 2'b00;
    m_wr = '0; m_locked = 0;
    #3;
    chk("rst_ready", cfg_ready, 1'b1);
    chk("rst_done", cfg_done, 1'b0);
    chk("rst_locked", cfg_locked, 1'b0);
    chk("rst_err", cfg_err, 1'b0);
    chk("rst_in", io_right_in, '0);
    chk("rst_pad", pad, '0);
    @(posedge prog_clk); #1;
    prog_rst_n = 1'b1;
    @(posedge prog_clk); #1;
  endtask

  // Full comparison of every output against the model, in two phases with
  // complementary fabric data so a stray driver cannot hide behind the pull.
  task automatic check_outputs(input string tag);
    logic [N-1:0] drv, pexp, iexp;
    for (int ph = 0; ph < 2; ph++) begin
      drv = m_drive();
      io_right_out = (ph == 0) ? N'($urandom) : ~io_right_out;
      ext_en = ext_req & ~drv;
      settle();
      for (int i = 0; i < N; i++) begin
        pexp[i] = drv[i] ? io_right_out[i] : (ext_en[i] ? ext_val[i] : 1'b0);
        iexp[i] = m_cfg[i][1] ? pexp[i] : 1'b0;
      end
      chk({tag, "_pad"}, pad, pexp);
      chk({tag, "_in"}, io_right_in, iexp);
    end
    chk({tag, "_done"}, cfg_done, m_done());
    chk({tag, "_locked"}, cfg_locked, m_locked);
    chk({tag, "_ready"}, cfg_ready, 1'b1);
    chk({tag, "_err"}, cfg_err, 1'b0);
  endtask

  // One write transaction starting from an idle (ready) cycle.
  task automatic wr(input int addr, input bit bc, input logic [1:0] d,
                    input bit hold, input bit lk);
    bit exp_err;
    logic [N-1:0] pre_drv;
    chk("ready_idle", cfg_ready, 1'b1);
    cfg_valid = 1; cfg_addr = AW'(addr); cfg_bcast = bc; cfg_data = d; cfg_lock = lk;
    exp_err = m_locked || (!bc && addr >= N);
    @(posedge prog_clk); #1;
    last_err_act = cfg_err;
    chk("err_pulse", cfg_err, exp_err);
    if (m_locked) begin
      cfg_valid = 0; cfg_lock = 0;
      chk("ready_locked", cfg_ready, 1'b1);
      @(posedge prog_clk); #1;
      chk("err_one_cycle", cfg_err, 1'b0);
    end else begin
      chk("ready_low", cfg_ready, 1'b0);
      chk("done_during_write", cfg_done, m_done());
      if (hold) begin
        cfg_data = ~d; cfg_addr = AW'($urandom); cfg_bcast = 1'($urandom);
      end else begin
        cfg_valid = 0;
      end
      pre_drv = m_drive();
      if (!exp_err) begin
        for (int i = 0; i < N; i++) begin
          if (bc || addr == i) begin
            m_cfg[i] = d;
            m_wr[i]  = 1'b1;
          end
        end
      end
      ext_en = ext_req & ~(pre_drv | m_drive());
      @(posedge prog_clk); #1;
      cfg_valid = 0;
      if (lk && m_done()) m_locked = 1;
      cfg_lock = 0;
      chk("ready_back", cfg_ready, 1'b1);
      chk("err_one_cycle", cfg_err, 1'b0);
    end
    fork
    join
  endtask

  typedef struct {
    int         addr;
    bit         bc;
    logic [1:0] d;
    bit         exp_err;
    bit         exp_done;
  } vec_t;

  vec_t vt [9];

  initial begin
    vt[0] = '{7, 1'b0, 2'd3, 1'b1, 1'b0};
    vt[1] = '{0, 1'b0, 2'd3, 1'b0, 1'b0};
    vt[2] = '{1, 1'b0, 2'd3, 1'b0, 1'b0};
    vt[3] = '{2, 1'b0, 2'd3, 1'b0, 1'b0};
    vt[4] = '{6, 1'b0, 2'd3, 1'b1, 1'b0};
    vt[5] = '{3, 1'b0, 2'd3, 1'b0, 1'b0};
    vt[6] = '{4, 1'b0, 2'd3, 1'b0, 1'b0};
    vt[7] = '{5, 1'b0, 2'd3, 1'b0, 1'b1};
    vt[8] = '{3, 1'b0, 2'd0, 1'b0, 1'b1};

    do_reset();

    // Lock request before configuration completes is ignored.
    cfg_lock = 1;
    @(posedge prog_clk); #1;
    cfg_lock = 0;
    chk("lock_ignored", cfg_locked, 1'b0);

    // Table-driven sequential configuration with range errors mixed in.
    for (int k = 0; k < 9; k++) begin
      wr(vt[k].addr, vt[k].bc, vt[k].d, 1'b0, 1'b0);
      chk("tbl_err", last_err_act, vt[k].exp_err);
      chk("tbl_done", cfg_done, vt[k].exp_done);
    end
    check_outputs("tbl");

    // Pads 0..5 enabled both ways except pad3 (cleared): loopback of 6'h2D.
    io_right_out = 6'h2D;
    ext_en = '0;
    settle();
    chk("loop_pad", pad, 6'h25);
    chk("loop_in", io_right_in, 6'h25);

    // Asynchronous reset while a write is in its WRITE state.
    io_right_out = 6'h3F;
    cfg_valid = 1; cfg_addr = 3'd3; cfg_bcast = 0; cfg_data = 2'b11;
    @(posedge prog_clk); #1;
    cfg_valid = 0;
    chk("mid_ready_low", cfg_ready, 1'b0);
    #2;
    prog_rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", cfg_ready, 1'b1);
    chk("mid_rst_done", cfg_done, 1'b0);
    chk("mid_rst_pad", pad, '0);
    chk("mid_rst_in", io_right_in, '0);
    for (int i = 0; i < N; i++) m_cfg[i] = 2'b00;
    m_wr = '0; m_locked = 0;
    @(posedge prog_clk); #1;
    prog_rst_n = 1'b1;
    repeat (2) @(posedge prog_clk);
    #1;
    chk("post_rst_done", cfg_done, 1'b0);
    chk("post_rst_pad", pad, '0);

    // Out-of-range write then broadcast of drive-only config.
    wr(7, 1'b0, 2'b11, 1'b0, 1'b0);
    chk("range_done", cfg_done, 1'b0);
    wr(5, 1'b1, 2'b01, 1'b0, 1'b0);
    io_right_out = 6'h15;
    settle();
    chk("bc01_pad", pad, 6'h15);
    chk("bc01_in", io_right_in, 6'h00);

    // Broadcast input-only config with external pads driving 6'h2B.
    wr(0, 1'b1, 2'b10, 1'b0, 1'b0);
    io_right_out = 6'h3F;
    ext_req = '1; ext_val = 6'h2B; ext_en = '1;
    settle();
    chk("bc10_pad", pad, 6'h2B);
    chk("bc10_in", io_right_in, 6'h2B);

    // Input path latency on a single pad toggle.
    @(posedge prog_clk); #1;
    ext_val = 6'h2A;
`ifdef GRID_IO_INPUT_SYNC_EN
    #1;
    chk("tog_t0", io_right_in, 6'h2B);
    @(posedge prog_clk); #1;
    chk("tog_e1", io_right_in, 6'h2B);
    @(posedge prog_clk); #1;
    chk("tog_e2", io_right_in, 6'h2A);
`else
    #1;
    chk("tog_t0", io_right_in, 6'h2A);
`endif

    // Lock, then a rejected write that leaves config intact.
    cfg_lock = 1;
    @(posedge prog_clk); #1;
    cfg_lock = 0;
    m_locked = m_done();
    chk("locked", cfg_locked, 1'b1);
    wr(0, 1'b0, 2'b01, 1'b0, 1'b0);
    chk("lock_rej_err", last_err_act, 1'b1);
    check_outputs("locked");

    // Lock requested together with the completing write.
    do_reset();
    wr(0, 1'b1, 2'b11, 1'b0, 1'b1);
    chk("lock_in_write", cfg_locked, 1'b1);
    check_outputs("lockw");

    // Randomized writes against the model.
    do_reset();
    for (int it = 0; it < 300; it++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) @(posedge prog_clk);
      #1;
      if ($urandom_range(0, 3) == 0) begin
        ext_req = N'($urandom);
        ext_val = N'($urandom);
      end
      ext_en = ext_req & ~m_drive();
      wr($urandom_range(0, 7), ($urandom_range(0, 9) == 0), 2'($urandom),
         1'($urandom), (it > 200) && ($urandom_range(0, 19) == 0));
      check_outputs("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
